mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch (F stage) and load/store (M stage).
- Holds each bus transaction stable until the memory handshake completes, then returns the read data to the winning requester.
- Produces per-stage stall requests that the hazard logic ORs into the pipeline freeze.
- Data access always has priority over fetch.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 32;
    localparam int unsigned MEM_DATA_WIDTH = 32;
    localparam int unsigned MEM_STRB_WIDTH = MEM_DATA_WIDTH / 8;

    localparam logic [MEM_STRB_WIDTH-1:0] ARB_STRB_ALL = {MEM_STRB_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FETCH,
        ARB_DATA
    } arb_state_t;

    typedef struct packed {
        logic                      wen;
        logic [MEM_STRB_WIDTH-1:0] wstrb;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] wdata;
    } mem_bus_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and load/store; data access wins, each
// transaction is held until bus_ready and results stay sticky until consumed.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pipe_advance,

    input  logic                    F_req,
    input  logic [ADDR_WIDTH-1:0]   F_addr,
    input  logic                    F_kill,
    output logic [DATA_WIDTH-1:0]   F_rdata,
    output logic                    F_stall,

    input  logic                    M_req,
    input  logic                    M_wen,
    input  logic [DATA_WIDTH/8-1:0] M_wstrb,
    input  logic [ADDR_WIDTH-1:0]   M_addr,
    input  logic [DATA_WIDTH-1:0]   M_wdata,
    output logic [DATA_WIDTH-1:0]   M_rdata,
    output logic                    M_stall,

    output logic                    bus_req,
    output logic                    bus_wen,
    output logic [DATA_WIDTH/8-1:0] bus_wstrb,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    arb_state_t              state_q, state_d;
    mem_bus_req_t            bus_q, bus_d;
    logic                    bus_req_q, bus_req_d;
    logic                    f_done_q, f_done_d;
    logic                    m_done_q, m_done_d;
    logic                    kill_pend_q, kill_pend_d;
    logic [DATA_WIDTH-1:0]   f_rdata_q, f_rdata_d;
    logic [DATA_WIDTH-1:0]   m_rdata_q, m_rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            bus_q       <= '0;
            bus_req_q   <= 1'b0;
            f_done_q    <= 1'b0;
            m_done_q    <= 1'b0;
            kill_pend_q <= 1'b0;
            f_rdata_q   <= '0;
            m_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            bus_req_q   <= bus_req_d;
            f_done_q    <= f_done_d;
            m_done_q    <= m_done_d;
            kill_pend_q <= kill_pend_d;
            f_rdata_q   <= f_rdata_d;
            m_rdata_q   <= m_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        bus_req_d   = bus_req_q;
        f_done_d    = f_done_q;
        m_done_d    = m_done_q;
        kill_pend_d = kill_pend_q;
        f_rdata_d   = f_rdata_q;
        m_rdata_d   = m_rdata_q;

        // Clears first; a completion below overrides them because the
        // completing request has not yet been counted by pipe_advance.
        if (pipe_advance) begin
            f_done_d = 1'b0;
            m_done_d = 1'b0;
        end
        if (F_kill) begin
            f_done_d = 1'b0;
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (M_req && !m_done_q) begin
                    bus_d.wen   = M_wen;
                    bus_d.wstrb = M_wen ? M_wstrb : ARB_STRB_ALL;
                    bus_d.addr  = M_addr;
                    bus_d.wdata = M_wdata;
                    bus_req_d   = 1'b1;
                    state_d     = ARB_DATA;
                end else if (F_req && !f_done_q && !F_kill) begin
                    bus_d.wen   = 1'b0;
                    bus_d.wstrb = ARB_STRB_ALL;
                    bus_d.addr  = F_addr;
                    bus_d.wdata = '0;
                    bus_req_d   = 1'b1;
                    state_d     = ARB_FETCH;
                end
            end

            ARB_FETCH: begin
                if (bus_ready) begin
                    bus_req_d   = 1'b0;
                    state_d     = ARB_IDLE;
                    kill_pend_d = 1'b0;
                    if (!kill_pend_q && !F_kill) begin
                        f_rdata_d = bus_rdata;
                        f_done_d  = 1'b1;
                    end
                end else if (F_kill) begin
                    kill_pend_d = 1'b1;
                end
            end

            ARB_DATA: begin
                if (bus_ready) begin
                    bus_req_d = 1'b0;
                    state_d   = ARB_IDLE;
                    m_done_d  = 1'b1;
                    if (!bus_q.wen) begin
                        m_rdata_d = bus_rdata;
                    end
                end
            end

            default: begin
                state_d   = ARB_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    assign bus_req   = bus_req_q;
    assign bus_wen   = bus_q.wen;
    assign bus_wstrb = bus_q.wstrb;
    assign bus_addr  = bus_q.addr;
    assign bus_wdata = bus_q.wdata;

    assign F_rdata = f_rdata_q;
    assign M_rdata = m_rdata_q;
    assign F_stall = F_req & ~f_done_q;
    assign M_stall = M_req & ~m_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level
// model of the shared memory port.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_advance;
    logic        F_req;
    logic [31:0] F_addr;
    logic        F_kill;
    logic [31:0] F_rdata;
    logic        F_stall;
    logic        M_req;
    logic        M_wen;
    logic [3:0]  M_wstrb;
    logic [31:0] M_addr;
    logic [31:0] M_wdata;
    logic [31:0] M_rdata;
    logic        M_stall;
    logic        bus_req;
    logic        bus_wen;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_advance(pipe_advance),
        .F_req(F_req), .F_addr(F_addr), .F_kill(F_kill),
        .F_rdata(F_rdata), .F_stall(F_stall),
        .M_req(M_req), .M_wen(M_wen), .M_wstrb(M_wstrb), .M_addr(M_addr),
        .M_wdata(M_wdata), .M_rdata(M_rdata), .M_stall(M_stall),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int tx_count = 0;
    logic prev_req = 1'b0;

    // Reference: one outstanding transaction record plus sticky results.
    logic        m_busy, m_is_data, m_fdone, m_mdone, m_kpend;
    logic        t_wen;
    logic [3:0]  t_strb;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] m_frdata, m_mrdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_is_data = 0; m_fdone = 0; m_mdone = 0; m_kpend = 0;
        t_wen = 0; t_strb = '0; t_addr = '0; t_wdata = '0;
        m_frdata = '0; m_mrdata = '0;
        prev_req = 1'b0;
    endtask

    task automatic model_step();
        logic nf, nm;
        nf = m_fdone;
        nm = m_mdone;
        if (pipe_advance) begin nf = 0; nm = 0; end
        if (F_kill) nf = 0;
        if (m_busy) begin
            if (bus_ready) begin
                m_busy = 0;
                if (m_is_data) begin
                    nm = 1;
                    if (!t_wen) m_mrdata = bus_rdata;
                end else if (m_kpend || F_kill) begin
                    m_kpend = 0;
                end else begin
                    nf = 1;
                    m_frdata = bus_rdata;
                end
            end else if (!m_is_data && F_kill) begin
                m_kpend = 1;
            end
        end else if (M_req && !m_mdone) begin
            m_busy = 1; m_is_data = 1;
            t_wen = M_wen; t_strb = M_wen ? M_wstrb : 4'hF;
            t_addr = M_addr; t_wdata = M_wdata;
        end else if (F_req && !m_fdone && !F_kill) begin
            m_busy = 1; m_is_data = 0;
            t_wen = 0; t_strb = 4'hF; t_addr = F_addr; t_wdata = '0;
        end
        m_fdone = nf;
        m_mdone = nm;
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic fk,
                         input logic mr, input logic mw, input logic [3:0] ms,
                         input logic [31:0] ma, input logic [31:0] md,
                         input logic adv, input logic rdy, input logic [31:0] rd);
        F_req = fr; F_addr = fa; F_kill = fk;
        M_req = mr; M_wen = mw; M_wstrb = ms; M_addr = ma; M_wdata = md;
        pipe_advance = adv; bus_ready = rdy; bus_rdata = rd;
    endtask

    // Called #1 after a negedge: compare against the model, then clock once.
    task automatic tick();
        check_eq("bus_req", {31'b0, bus_req}, {31'b0, m_busy});
        if (m_busy) begin
            check_eq("bus_addr", bus_addr, t_addr);
            check_eq("bus_wen", {31'b0, bus_wen}, {31'b0, t_wen});
            check_eq("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, t_strb});
            if (t_wen) check_eq("bus_wdata", bus_wdata, t_wdata);
        end
        check_eq("F_stall", {31'b0, F_stall}, {31'b0, F_req & ~m_fdone});
        check_eq("M_stall", {31'b0, M_stall}, {31'b0, M_req & ~m_mdone});
        check_eq("F_rdata", F_rdata, m_frdata);
        check_eq("M_rdata", M_rdata, m_mrdata);
        if (bus_req && !prev_req) tx_count++;
        prev_req = bus_req;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, m_busy, 32'h0);
            #1;
            tick();
        end
    endtask

    int tx0;
    logic rf, rm, rw, fk, adv, rdy, adv_prev;
    logic [31:0] rfa, rma, rmd;
    logic [3:0] rms;

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_bus_req", {31'b0, bus_req}, 32'h0);
        check_eq("rst_bus_addr", bus_addr, 32'h0);
        check_eq("rst_bus_wen", {31'b0, bus_wen}, 32'h0);
        check_eq("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
        check_eq("rst_F_rdata", F_rdata, 32'h0);
        check_eq("rst_M_rdata", M_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch, ready one cycle after bus_req.
        drive(1, 32'h100, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0); #1;
        check_eq("s1_stall_c0", {31'b0, F_stall}, 32'h1);
        tick();
        drive(1, 32'h100, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h0050_0093); #1;
        check_eq("s1_bus_addr", bus_addr, 32'h100);
        check_eq("s1_bus_wen", {31'b0, bus_wen}, 32'h0);
        tick();
        drive(1, 32'h100, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0); #1;
        check_eq("s1_stall_c2", {31'b0, F_stall}, 32'h0);
        check_eq("s1_rdata", F_rdata, 32'h0050_0093);
        tick();
        drive(1, 32'h104, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0); #1;
        check_eq("s1_done_cleared", {31'b0, F_stall}, 32'h1);
        tick();
        drive(1, 32'h104, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h1234_5678); #1; tick();
        drive(1, 32'h104, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0); #1; tick();
        idle_cycles(2);

        // Simultaneous fetch and load: data first.
        drive(1, 32'h104, 0, 1, 0, 4'h0, 32'h2000, 0, 0, 0, 0); #1; tick();
        drive(1, 32'h104, 0, 1, 0, 4'h0, 32'h2000, 0, 0, 1, 32'h1111_2222); #1;
        check_eq("s2_data_first", bus_addr, 32'h2000);
        tick();
        drive(1, 32'h104, 0, 1, 0, 4'h0, 32'h2000, 0, 0, 0, 0); #1;
        check_eq("s2_M_stall", {31'b0, M_stall}, 32'h0);
        check_eq("s2_F_stall", {31'b0, F_stall}, 32'h1);
        check_eq("s2_M_rdata", M_rdata, 32'h1111_2222);
        tick();
        drive(1, 32'h104, 0, 1, 0, 4'h0, 32'h2000, 0, 0, 1, 32'h3333_4444); #1;
        check_eq("s2_fetch_next", bus_addr, 32'h104);
        tick();
        drive(1, 32'h104, 0, 1, 0, 4'h0, 32'h2000, 0, 1, 0, 0); #1;
        check_eq("s2_both_clear", {30'b0, F_stall, M_stall}, 32'h0);
        tick();
        idle_cycles(2);

        // Store with delayed ready, then frozen pipeline.
        tx0 = tx_count;
        drive(0, 0, 0, 1, 1, 4'b0011, 32'h3000, 32'hDEAD_BEEF, 0, 0, 0); #1; tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 1, 4'b0011, 32'h3000, 32'hDEAD_BEEF, 0, 0, 0); #1;
            check_eq("s3_hold_req", {31'b0, bus_req}, 32'h1);
            check_eq("s3_hold_addr", bus_addr, 32'h3000);
            check_eq("s3_hold_wstrb", {28'b0, bus_wstrb}, 32'h3);
            check_eq("s3_hold_wdata", bus_wdata, 32'hDEAD_BEEF);
            tick();
        end
        drive(0, 0, 0, 1, 1, 4'b0011, 32'h3000, 32'hDEAD_BEEF, 0, 1, 32'h0BAD_0BAD); #1; tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 1, 4'b0011, 32'h3000, 32'hDEAD_BEEF, 0, 0, 0); #1;
            check_eq("s4_M_stall", {31'b0, M_stall}, 32'h0);
            check_eq("s4_no_reissue", {31'b0, bus_req}, 32'h0);
            check_eq("s4_M_rdata", M_rdata, 32'h1111_2222);
            tick();
        end
        drive(0, 0, 0, 1, 1, 4'b0011, 32'h3000, 32'hDEAD_BEEF, 1, 0, 0); #1; tick();
        idle_cycles(1);
        check_eq("s4_one_store", tx_count - tx0, 32'd1);

        // Kill during an outstanding fetch.
        drive(1, 32'h200, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0); #1; tick();
        drive(1, 32'h300, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0); #1;
        check_eq("s5_addr_200", bus_addr, 32'h200);
        tick();
        drive(1, 32'h300, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hBAD0_0200); #1;
        check_eq("s5_tx_held", bus_addr, 32'h200);
        tick();
        drive(1, 32'h300, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0); #1;
        check_eq("s5_dropped_stall", {31'b0, F_stall}, 32'h1);
        check_eq("s5_dropped_rdata", F_rdata, 32'h3333_4444);
        tick();
        drive(1, 32'h300, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h0030_0013); #1;
        check_eq("s5_addr_300", bus_addr, 32'h300);
        tick();
        drive(1, 32'h300, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0); #1;
        check_eq("s5_rdata_300", F_rdata, 32'h0030_0013);
        check_eq("s5_stall", {31'b0, F_stall}, 32'h0);
        tick();
        idle_cycles(2);

        // Reset in the middle of a data transaction.
        drive(1, 32'h500, 0, 1, 0, 4'h0, 32'h4000, 0, 0, 0, 0); #1; tick();
        drive(1, 32'h500, 0, 1, 0, 4'h0, 32'h4000, 0, 0, 0, 0); #1;
        check_eq("s6_pre_req", {31'b0, bus_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("s6_rst_req", {31'b0, bus_req}, 32'h0);
        check_eq("s6_rst_M_stall", {31'b0, M_stall}, 32'h1);
        check_eq("s6_rst_F_stall", {31'b0, F_stall}, 32'h1);
        check_eq("s6_rst_M_rdata", M_rdata, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h500, 0, 1, 0, 4'h0, 32'h4000, 0, 0, 0, 0); #1; tick();
        drive(1, 32'h500, 0, 1, 0, 4'h0, 32'h4000, 0, 0, 1, 32'hCAFE_F00D); #1;
        check_eq("s6_rearb", bus_addr, 32'h4000);
        tick();
        drive(1, 32'h500, 0, 1, 0, 4'h0, 32'h4000, 0, 0, 0, 0); #1;
        check_eq("s6_M_rdata", M_rdata, 32'hCAFE_F00D);
        tick();
        drive(1, 32'h500, 0, 1, 0, 4'h0, 32'h4000, 0, 0, 1, 32'h0000_0513); #1; tick();
        drive(1, 32'h500, 0, 1, 0, 4'h0, 32'h4000, 0, 1, 0, 0); #1; tick();
        idle_cycles(2);

        // Randomized pipeline-like traffic.
        adv_prev = 1'b1;
        rf = 0; rm = 0; rw = 0; rfa = 0; rma = 0; rmd = 0; rms = 0;
        for (int c = 0; c < 3000; c++) begin
            if (adv_prev) begin
                rf  = ($urandom_range(0, 3) != 0);
                rfa = $urandom & 32'h0000_FFFC;
                rm  = ($urandom_range(0, 2) == 0);
                rw  = $urandom_range(0, 1);
                rms = 4'($urandom_range(0, 15));
                rma = $urandom & 32'h0000_FFFC;
                rmd = $urandom;
            end
            fk = ($urandom_range(0, 15) == 0);
            if (fk) rfa = $urandom & 32'h0000_FFFC;
            adv = !(rf && !m_fdone && !fk) && !(rm && !m_mdone) && ($urandom_range(0, 3) != 0);
            rdy = m_busy && ($urandom_range(0, 2) == 0);
            drive(rf, rfa, fk, rm, rw, rms, rma, rmd, adv, rdy, mem_word(t_addr));
            #1;
            tick();
            adv_prev = adv;
        end
        idle_cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
